// File: rtl/scanline_bank_writer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scanline_bank_writer_pkg : shared FSM encoding and width helpers       |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package scanline_bank_writer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam int SHORT_W = 8;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/scanline_bank_writer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scanline_bank_writer_if : sensor sample stream with start-of-line tag  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface scanline_bank_writer_if #(
   parameter int DATA_W = 8
) ();
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_sol;

   modport master (output s_valid, output s_data, output s_sol, input s_ready);
   modport slave  (input s_valid, input s_data, input s_sol, output s_ready);
endinterface
`default_nettype wire

// File: rtl/scanline_bank_writer_bank_alloc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scanline_bank_writer_bank_alloc : round-robin free line-buffer finder  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module scanline_bank_writer_bank_alloc
   import scanline_bank_writer_pkg::*;
#(
   parameter int NUM_BANKS = 4,
   localparam int BANK_W   = clog2(NUM_BANKS)
) (
   input  wire [NUM_BANKS-1:0] i_full,
   input  wire [BANK_W-1:0]    i_start,
   output logic [BANK_W-1:0]   o_idx,
   output logic                o_found
);

   logic [BANK_W-1:0] w_cand;

   // Scan from the far end so the bank closest to i_start is the last one taken.
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      w_cand  = '0;
      for (int i = NUM_BANKS - 1; i >= 0; i--) begin
         w_cand = i_start + BANK_W'(i);
         if (!i_full[w_cand]) begin
            o_idx   = w_cand;
            o_found = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/scanline_bank_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | scanline_bank_writer : writes scanlines into NUM_BANKS memory buffers  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module scanline_bank_writer
   import scanline_bank_writer_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 12,
   parameter int LINE_LEN  = 1024,
   parameter int NUM_BANKS = 4,
   localparam int BANK_W   = clog2(NUM_BANKS)
) (
   input  wire                   clk_clk,
   input  wire                   reset_reset,
   scanline_bank_writer_if.slave s_if,
   input  wire                   mode_bin,
   input  wire [DATA_W-1:0]      threshold,
   input  wire                   rel_valid,
   input  wire [BANK_W-1:0]      rel_bank,
   output logic [ADDR_W-1:0]     mem_address,
   output logic                  mem_chipselect,
   output logic                  mem_clken,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  line_done,
   output logic [BANK_W-1:0]     line_bank,
   output logic [NUM_BANKS-1:0]  bank_full,
   output logic [SHORT_W-1:0]    short_lines
);

   localparam int               IDX_W      = clog2(LINE_LEN);
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(LINE_LEN - 1);

   state_t                r_state;
   logic [BANK_W-1:0]     r_cur;
   logic [IDX_W-1:0]      r_idx;
   logic [NUM_BANKS-1:0]  r_full;
   logic [SHORT_W-1:0]    r_short;
   logic                  r_line_done;
   logic [BANK_W-1:0]     r_line_bank;
   logic                  r_mem_write;
   logic [ADDR_W-1:0]     r_mem_addr;
   logic [DATA_W-1:0]     r_mem_data;
   logic                  r_clken;

   state_t                w_next_state;
   logic                  w_ready;
   logic                  w_wr;
   logic [IDX_W-1:0]      w_wr_idx;
   logic [IDX_W-1:0]      w_idx_next;
   logic [BANK_W-1:0]     w_cur_next;
   logic                  w_abort;
   logic                  w_commit;
   logic [NUM_BANKS-1:0]  w_cur_mask;
   logic [NUM_BANKS-1:0]  w_set_mask;
   logic [NUM_BANKS-1:0]  w_rel_mask;
   logic [NUM_BANKS-1:0]  w_alloc_full;
   logic [BANK_W-1:0]     w_alloc_idx;
   logic                  w_found;
   logic [DATA_W-1:0]     w_wdata;
   logic [ADDR_W-1:0]     w_addr;

   // During COMMIT the bank being closed must already look occupied to the allocator.
   assign w_cur_mask   = NUM_BANKS'(1) << r_cur;
   assign w_alloc_full = (r_state == ST_COMMIT) ? (r_full | w_cur_mask) : r_full;
   assign w_set_mask   = w_commit ? w_cur_mask : '0;
   assign w_rel_mask   = rel_valid ? ((NUM_BANKS'(1) << rel_bank) & ~w_set_mask) : '0;

   assign w_wdata = mode_bin ? ((s_if.s_data >= threshold) ? {DATA_W{1'b1}} : {DATA_W{1'b0}})
                             : s_if.s_data;
   assign w_addr  = ADDR_W'(r_cur) * ADDR_W'(LINE_LEN) + ADDR_W'(w_wr_idx);

   scanline_bank_writer_bank_alloc #(
      .NUM_BANKS (NUM_BANKS)
   ) u_bank_alloc (
      .i_full  (w_alloc_full),
      .i_start (r_cur + BANK_W'(1)),
      .o_idx   (w_alloc_idx),
      .o_found (w_found)
   );

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_ready      = 1'b0;
      w_wr         = 1'b0;
      w_wr_idx     = '0;
      w_idx_next   = r_idx;
      w_cur_next   = r_cur;
      w_abort      = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready = ~r_full[r_cur];
            if (r_full[r_cur]) begin
               if (w_found) begin
                  w_cur_next = w_alloc_idx;
               end
            end else if (s_if.s_valid && s_if.s_sol) begin
               w_wr         = 1'b1;
               w_idx_next   = IDX_W'(1);
               w_next_state = ST_WRITE;
            end
         end
         ST_WRITE: begin
            w_ready = 1'b1;
            if (s_if.s_valid) begin
               w_wr = 1'b1;
               if (s_if.s_sol) begin
                  w_abort    = (r_idx != '0);
                  w_idx_next = IDX_W'(1);
               end else begin
                  w_wr_idx = r_idx;
                  if (r_idx == C_LAST_IDX) begin
                     w_idx_next   = '0;
                     w_next_state = ST_COMMIT;
                  end else begin
                     w_idx_next = r_idx + IDX_W'(1);
                  end
               end
            end
         end
         ST_COMMIT: begin
            w_commit     = 1'b1;
            w_next_state = ST_IDLE;
            if (w_found) begin
               w_cur_next = w_alloc_idx;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_cur       <= '0;
         r_idx       <= '0;
         r_full      <= '0;
         r_short     <= '0;
         r_line_done <= 1'b0;
         r_line_bank <= '0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_data  <= '0;
         r_clken     <= 1'b0;
      end else begin
         r_clken     <= 1'b1;
         r_cur       <= w_cur_next;
         r_idx       <= w_idx_next;
         r_full      <= (r_full & ~w_rel_mask) | w_set_mask;
         r_line_done <= w_commit;
         r_mem_write <= w_wr;
         if (w_abort && (r_short != {SHORT_W{1'b1}})) begin
            r_short <= r_short + SHORT_W'(1);
         end
         if (w_commit) begin
            r_line_bank <= r_cur;
         end
         if (w_wr) begin
            r_mem_addr <= w_addr;
            r_mem_data <= w_wdata;
         end
      end
   end

   // Ready is forced low while reset is held so the front end never sees a phantom accept.
   assign s_if.s_ready   = w_ready & ~reset_reset;
   assign mem_address    = r_mem_addr;
   assign mem_chipselect = r_mem_write;
   assign mem_clken      = r_clken;
   assign mem_write      = r_mem_write;
   assign mem_writedata  = r_mem_data;
   assign line_done      = r_line_done;
   assign line_bank      = r_line_bank;
   assign bank_full      = r_full;
   assign short_lines    = r_short;

endmodule
`default_nettype wire

// File: tb/tb_scanline_bank_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_scanline_bank_writer : scoreboard bench for scanline_bank_writer    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_scanline_bank_writer;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 12;
   localparam int LINE_LEN  = 1024;
   localparam int NUM_BANKS = 4;
   localparam int BANK_W    = 2;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 mode_bin = 1'b0;
   logic [DATA_W-1:0]    threshold = '0;
   logic                 rel_valid = 1'b0;
   logic [BANK_W-1:0]    rel_bank = '0;
   logic [ADDR_W-1:0]    mem_address;
   logic                 mem_chipselect;
   logic                 mem_clken;
   logic                 mem_write;
   logic [DATA_W-1:0]    mem_writedata;
   logic                 line_done;
   logic [BANK_W-1:0]    line_bank;
   logic [NUM_BANKS-1:0] bank_full;
   logic [7:0]           short_lines;

   int n_cmp = 0;
   int n_bad = 0;

   wr_t              exp_q[$];
   logic [BANK_W-1:0] ld_q[$];

   // Reference model: what the memory map should look like from the line/bank rules.
   bit                   m_in_line;
   int                   m_idx;
   int                   m_cur;
   int                   m_short;
   int                   m_last;
   logic [NUM_BANKS-1:0] m_full;

   always #5 clk = ~clk;

   scanline_bank_writer_if #(.DATA_W(DATA_W)) s_if ();

   scanline_bank_writer #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .LINE_LEN  (LINE_LEN),
      .NUM_BANKS (NUM_BANKS)
   ) dut (
      .clk_clk        (clk),
      .reset_reset    (rst),
      .s_if           (s_if),
      .mode_bin       (mode_bin),
      .threshold      (threshold),
      .rel_valid      (rel_valid),
      .rel_bank       (rel_bank),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_clken      (mem_clken),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .line_done      (line_done),
      .line_bank      (line_bank),
      .bank_full      (bank_full),
      .short_lines    (short_lines)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int next_free(input int from);
      for (int i = 1; i <= NUM_BANKS; i++) begin
         if (!m_full[(from + i) % NUM_BANKS]) return (from + i) % NUM_BANKS;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_in_line = 0;
      m_idx     = 0;
      m_cur     = 0;
      m_short   = 0;
      m_last    = 0;
      m_full    = '0;
   endtask

   task automatic push_wr(input int addr, input logic [DATA_W-1:0] d);
      wr_t e;
      e.addr = ADDR_W'(addr);
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic model_accept(input bit sol, input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] w;
      int nf;
      w = mode_bin ? ((d >= threshold) ? 8'hFF : 8'h00) : d;
      if (!m_in_line) begin
         if (sol) begin
            push_wr(m_cur * LINE_LEN, w);
            m_idx     = 1;
            m_in_line = 1;
         end
      end else if (sol) begin
         if (m_short < 255) m_short++;
         push_wr(m_cur * LINE_LEN, w);
         m_idx = 1;
      end else begin
         push_wr(m_cur * LINE_LEN + m_idx, w);
         m_idx++;
         if (m_idx == LINE_LEN) begin
            ld_q.push_back(BANK_W'(m_cur));
            m_last        = m_cur;
            m_full[m_cur] = 1'b1;
            m_in_line     = 0;
            nf = next_free(m_cur);
            if (nf >= 0) m_cur = nf;
         end
      end
   endtask

   task automatic model_release(input int b);
      int nf;
      m_full[b] = 1'b0;
      if (m_full[m_cur]) begin
         nf = next_free(m_cur);
         if (nf >= 0) m_cur = nf;
      end
   endtask

   task automatic send(input bit sol, input logic [DATA_W-1:0] d);
      bit acc;
      acc = 0;
      s_if.s_valid = 1'b1;
      s_if.s_sol   = sol;
      s_if.s_data  = d;
      for (int t = 0; t < 2000 && !acc; t++) begin
         @(negedge clk);
         if (s_if.s_ready) begin
            acc = 1;
            model_accept(sol, d);
         end
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: got no s_ready, expected acceptance within 2000 cycles");
      end
      s_if.s_valid = 1'b0;
      s_if.s_sol   = 1'b0;
      if ($urandom_range(3) == 0) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_line(input bit rand_mode);
      send(1'b1, DATA_W'($urandom));
      for (int i = 1; i < LINE_LEN; i++) begin
         if (rand_mode) begin
            mode_bin  = 1'($urandom_range(1));
            threshold = DATA_W'($urandom);
         end
         send(1'b0, DATA_W'($urandom));
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic release_bank(input int b);
      rel_valid = 1'b1;
      rel_bank  = BANK_W'(b);
      @(posedge clk);
      #1;
      rel_valid = 1'b0;
      model_release(b);
      wait_cycles(2);
   endtask

   task automatic check_line_state(input string tag);
      check({tag, "_bank_full"}, 32'(bank_full), 32'(m_full));
      check({tag, "_line_bank"}, 32'(line_bank), 32'(m_last));
      check({tag, "_short"}, 32'(short_lines), 32'(m_short));
      check({tag, "_pending_done"}, 32'(ld_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
      check({tag, "_chipselect"}, 32'(mem_chipselect), 32'd0);
      check({tag, "_clken"}, 32'(mem_clken), 32'd0);
      check({tag, "_address"}, 32'(mem_address), 32'd0);
      check({tag, "_writedata"}, 32'(mem_writedata), 32'd0);
      check({tag, "_line_done"}, 32'(line_done), 32'd0);
      check({tag, "_line_bank"}, 32'(line_bank), 32'd0);
      check({tag, "_bank_full"}, 32'(bank_full), 32'd0);
      check({tag, "_short"}, 32'(short_lines), 32'd0);
      check({tag, "_s_ready"}, 32'(s_if.s_ready), 32'd0);
   endtask

   // Monitor: every DUT write and line_done pulse is matched against the queued expectation.
   always @(negedge clk) begin : mon
      wr_t e;
      logic [BANK_W-1:0] eb;
      if (!rst) begin
         if (mem_write) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                        mem_address, mem_writedata);
            end else begin
               e = exp_q.pop_front();
               if (mem_address !== e.addr || mem_writedata !== e.data || mem_chipselect !== 1'b1) begin
                  n_bad++;
                  $display("FAIL write: got addr 0x%0h data 0x%0h cs %0b, expected addr 0x%0h data 0x%0h cs 1",
                           mem_address, mem_writedata, mem_chipselect, e.addr, e.data);
               end
            end
         end
         if (line_done) begin
            n_cmp++;
            if (ld_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_line_done: got bank %0d, expected no pulse", line_bank);
            end else begin
               eb = ld_q.pop_front();
               if (line_bank !== eb) begin
                  n_bad++;
                  $display("FAIL line_done_bank: got %0d, expected %0d", line_bank, eb);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      s_if.s_valid = 1'b0;
      s_if.s_sol   = 1'b0;
      s_if.s_data  = '0;
      model_reset();
      wait_cycles(3);
      check_reset_outputs("por");
      @(negedge clk);
      rst = 1'b0;
      wait_cycles(2);
      check("clken_after_reset", 32'(mem_clken), 32'd1);

      // Samples without a start-of-line are swallowed; releasing an empty bank is a no-op.
      for (int i = 0; i < 5; i++) send(1'b0, DATA_W'($urandom));
      release_bank(1);
      check("bogus_release_full", 32'(bank_full), 32'(m_full));
      check("drop_pending_writes", 32'(exp_q.size()), 32'd0);

      // Raw ramp into bank 0.
      send(1'b1, 8'h00);
      for (int i = 1; i < LINE_LEN; i++) send(1'b0, DATA_W'(i % 256));
      wait_cycles(4);
      check_line_state("raw");

      // Binarise, then a short line aborted by a fresh start-of-line.
      mode_bin  = 1'b1;
      threshold = 8'h80;
      send(1'b1, 8'h7F);
      send(1'b0, 8'h80);
      for (int i = 0; i < 8; i++) send(1'b0, DATA_W'($urandom));
      send_line(1'b1);
      wait_cycles(4);
      check_line_state("short");
      check("short_count_one", 32'(short_lines), 32'd1);

      // Fill remaining banks; the writer must stall with all buffers occupied.
      send_line(1'b1);
      send_line(1'b1);
      wait_cycles(4);
      check_line_state("fill");
      @(negedge clk);
      check("ready_when_all_full", 32'(s_if.s_ready), 32'd0);
      wait_cycles(1);

      release_bank(2);
      send_line(1'b1);
      wait_cycles(4);
      check_line_state("after_rel2");

      release_bank(0);
      release_bank(1);
      release_bank(0);
      check("double_release_full", 32'(bank_full), 32'(m_full));
      mode_bin = 1'b0;
      send_line(1'b0);
      wait_cycles(4);
      check_line_state("after_rel01");

      // Asynchronous reset in the middle of a line.
      send(1'b1, DATA_W'($urandom));
      for (int i = 1; i < 500; i++) send(1'b0, DATA_W'($urandom));
      rst = 1'b1;
      exp_q.delete();
      ld_q.delete();
      model_reset();
      #1;
      check_reset_outputs("midline");
      @(negedge clk);
      rst = 1'b0;
      wait_cycles(1);
      send(1'b1, DATA_W'($urandom));
      for (int i = 0; i < 20; i++) send(1'b0, DATA_W'($urandom));
      wait_cycles(4);
      check_line_state("post_reset");
      check("final_pending_writes", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
